// File: rtl/gated_pkt_gen_pkg.sv
// Shared types and constants for the gated packet generator.
// The header beat is packed LSB-first: magic, packet length, sequence number.
package gated_pkt_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam logic [15:0] HDR_MAGIC = 16'hA5A5;
    localparam int          MAGIC_W   = 16;
    localparam int          LEN_W     = 16;
    localparam int          SEQ_W     = 32;
    localparam int          IDX_W     = 32;
    localparam int          HDR_W     = SEQ_W + LEN_W + MAGIC_W;
    localparam int          STAT_W    = 32;

    // Builds the 64 meaningful bits of a beat; callers zero-extend to the bus width.
    function automatic logic [HDR_W-1:0] make_beat(
        input logic [SEQ_W-1:0] seq,
        input logic [15:0]      idx,
        input logic [LEN_W-1:0] words
    );
        if (idx == 16'd0) begin
            make_beat = {seq, words, HDR_MAGIC};
        end else begin
            make_beat = {seq, 16'h0000, idx};
        end
    endfunction

endpackage

// File: rtl/gated_pkt_gen_stats.sv
// Stall statistics: counts cycles where the stream offers a beat that the
// sink refuses. Saturates rather than wrapping so a long stall stays visible.
module gated_pkt_gen_stats
    import gated_pkt_gen_pkg::*;
(
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              clr_i,
    input  logic              tvalid_i,
    input  logic              tready_i,
    output logic [STAT_W-1:0] stall_count_o
);

    logic [STAT_W-1:0] stall_q;

    // Saturating stall counter, held at zero while the soft clear is active.
    always_ff @(posedge aclk) begin
        if (!aresetn || clr_i) begin
            stall_q <= '0;
        end else if (tvalid_i && !tready_i && (stall_q != {STAT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_count_o = stall_q;

endmodule

// File: rtl/gated_pkt_gen.sv
// Gated AXI-Stream packet generator. Emits fixed-length packets while the
// upstream gate is open, separated by a programmable idle gap.
// Optional stall statistics are built only when GATED_PKT_GEN_STATS_EN is
// defined; otherwise stall_count is tied to zero.
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both high. Once tvalid is raised, tvalid, tdata and tlast are held until
// that transfer; tready never feeds back combinationally to any output.
module gated_pkt_gen
    import gated_pkt_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int PKT_WORDS  = 16,
    parameter int IFG_CYCLES = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    common_rst,
    input  logic                    common_gate,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [31:0]             tx_pkt_count,
    output logic                    busy,
    output logic [31:0]             stall_count
);

    localparam logic [15:0] LAST_BEAT = 16'(PKT_WORDS - 1);
    localparam logic [15:0] PKT_LEN   = 16'(PKT_WORDS);
    localparam logic [7:0]  GAP_LAST  = (IFG_CYCLES == 0) ? 8'd0 : 8'(IFG_CYCLES - 1);
    localparam bit          NO_GAP    = (IFG_CYCLES == 0);

    state_e                  state_q;
    logic [15:0]             beat_q;
    logic [7:0]              gap_q;
    logic                    tvalid_q;
    logic                    tlast_q;
    logic [DATA_WIDTH-1:0]   tdata_q;
    logic [31:0]             pkt_cnt_q;
    logic [SEQ_W-1:0]        seq_q;
    // Remembers a soft clear seen mid-packet so that packet is not counted.
    logic                    clr_seen_q;

    logic                    xfer_d;
    logic                    start_ok_d;
    logic [15:0]             beat_d;
    logic [DATA_WIDTH-1:0]   hdr_cur_d;
    logic [DATA_WIDTH-1:0]   hdr_next_d;
    logic [DATA_WIDTH-1:0]   body_d;

    // Next-beat index and candidate beat contents for every FSM exit.
    always_comb begin
        xfer_d     = tvalid_q & m_axis_tready;
        start_ok_d = common_gate & ~common_rst;
        beat_d     = beat_q + 16'd1;
        hdr_cur_d  = DATA_WIDTH'(make_beat(seq_q, 16'd0, PKT_LEN));
        hdr_next_d = DATA_WIDTH'(make_beat(seq_q + 32'd1, 16'd0, PKT_LEN));
        body_d     = DATA_WIDTH'(make_beat(seq_q, beat_d, PKT_LEN));
    end

    // Packet FSM with registered stream outputs and packet/sequence counters.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            gap_q      <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
            pkt_cnt_q  <= '0;
            seq_q      <= '0;
            clr_seen_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok_d) begin
                        state_q    <= SEND;
                        beat_q     <= '0;
                        tvalid_q   <= 1'b1;
                        tlast_q    <= 1'b0;
                        tdata_q    <= hdr_cur_d;
                        clr_seen_q <= 1'b0;
                    end
                end
                SEND: begin
                    if (common_rst) begin
                        clr_seen_q <= 1'b1;
                    end
                    if (xfer_d) begin
                        if (tlast_q) begin
                            if (common_rst || clr_seen_q) begin
                                state_q  <= IDLE;
                                tvalid_q <= 1'b0;
                                tlast_q  <= 1'b0;
                            end else begin
                                pkt_cnt_q <= pkt_cnt_q + 32'd1;
                                seq_q     <= seq_q + 32'd1;
                                if (NO_GAP && common_gate) begin
                                    beat_q     <= '0;
                                    tlast_q    <= 1'b0;
                                    tdata_q    <= hdr_next_d;
                                    clr_seen_q <= 1'b0;
                                end else if (NO_GAP) begin
                                    state_q  <= IDLE;
                                    tvalid_q <= 1'b0;
                                    tlast_q  <= 1'b0;
                                end else begin
                                    state_q  <= GAP;
                                    gap_q    <= '0;
                                    tvalid_q <= 1'b0;
                                    tlast_q  <= 1'b0;
                                end
                            end
                        end else begin
                            beat_q  <= beat_d;
                            tdata_q <= body_d;
                            tlast_q <= (beat_d == LAST_BEAT);
                        end
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        gap_q <= '0;
                        if (start_ok_d) begin
                            state_q    <= SEND;
                            beat_q     <= '0;
                            tvalid_q   <= 1'b1;
                            tlast_q    <= 1'b0;
                            tdata_q    <= hdr_cur_d;
                            clr_seen_q <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        gap_q <= gap_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            // The soft clear overrides any increment made above.
            if (common_rst) begin
                pkt_cnt_q <= '0;
                seq_q     <= '0;
            end
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = '1;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign tx_pkt_count  = pkt_cnt_q;
    assign busy          = (state_q != IDLE);

`ifdef GATED_PKT_GEN_STATS_EN
    gated_pkt_gen_stats u_stats (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .clr_i         (common_rst),
        .tvalid_i      (tvalid_q),
        .tready_i      (m_axis_tready),
        .stall_count_o (stall_count)
    );
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_gated_pkt_gen.sv
// Directed bench for gated_pkt_gen: a default instance (IFG 4) and a
// zero-gap instance for back-to-back packets.
module tb_gated_pkt_gen;

    logic        aclk;
    logic        aresetn;
    logic        common_rst;
    logic        common_gate;
    logic        tready;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic [31:0] pkt_cnt;
    logic        busy;
    logic [31:0] stall;

    logic        gate_b;
    logic        tready_b;
    logic [63:0] tdata_b;
    logic [7:0]  tkeep_b;
    logic        tvalid_b;
    logic        tlast_b;
    logic [31:0] pkt_cnt_b;
    logic        busy_b;
    logic [31:0] stall_b;

    int          total;
    int          bad;
    logic [31:0] exp_seq;
    logic [31:0] exp_cnt;
    logic [31:0] exp_stall;
    logic [63:0] exp_data;

    gated_pkt_gen #(.DATA_WIDTH(64), .PKT_WORDS(16), .IFG_CYCLES(4)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .common_rst    (common_rst),
        .common_gate   (common_gate),
        .m_axis_tdata  (tdata),
        .m_axis_tkeep  (tkeep),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .tx_pkt_count  (pkt_cnt),
        .busy          (busy),
        .stall_count   (stall)
    );

    gated_pkt_gen #(.DATA_WIDTH(64), .PKT_WORDS(16), .IFG_CYCLES(0)) dut_b (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .common_rst    (common_rst),
        .common_gate   (gate_b),
        .m_axis_tdata  (tdata_b),
        .m_axis_tkeep  (tkeep_b),
        .m_axis_tvalid (tvalid_b),
        .m_axis_tready (tready_b),
        .m_axis_tlast  (tlast_b),
        .tx_pkt_count  (pkt_cnt_b),
        .busy          (busy_b),
        .stall_count   (stall_b)
    );

    // Clock
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Expected beat contents, written straight from the packet format.
    function automatic logic [63:0] beat_val(input logic [31:0] seq, input int k);
        if (k == 0) return {seq, 16'h0010, 16'hA5A5};
        return {seq, 32'(k)};
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; common_rst = 1'b0; common_gate = 1'b0; gate_b = 1'b0;
        tready = 1'b1; tready_b = 1'b1;
        tick(); tick();
        total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%0b exp=0", tvalid); end
        total++; if (tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%0b exp=0", tlast); end
        total++; if (tdata !== 64'd0) begin bad++; $display("FAIL reset_tdata got=%h exp=0", tdata); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (pkt_cnt !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", pkt_cnt); end
        total++; if (stall !== 32'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall); end
        total++; if (tkeep !== 8'hFF) begin bad++; $display("FAIL reset_tkeep got=%h exp=ff", tkeep); end
        total++; if (tvalid_b !== 1'b0) begin bad++; $display("FAIL reset_tvalid_b got=%0b exp=0", tvalid_b); end
        aresetn = 1'b1;
        tick();
        exp_seq = 32'd0; exp_cnt = 32'd0; exp_stall = 32'd0;
    endtask

    task automatic test_back_to_back();
        gate_b = 1'b1;
        tick();
        for (int i = 0; i < 48; i++) begin
            if (i == 40) gate_b = 1'b0;
            exp_data = beat_val(32'(i / 16), i % 16);
            total++; if (tvalid_b !== 1'b1) begin bad++; $display("FAIL b2b_tvalid beat=%0d got=%0b exp=1", i, tvalid_b); end
            total++; if (tdata_b !== exp_data) begin bad++; $display("FAIL b2b_tdata beat=%0d got=%h exp=%h", i, tdata_b, exp_data); end
            total++; if (tlast_b !== ((i % 16) == 15)) begin bad++; $display("FAIL b2b_tlast beat=%0d got=%0b", i, tlast_b); end
            tick();
        end
        total++; if (tvalid_b !== 1'b0) begin bad++; $display("FAIL b2b_end_tvalid got=%0b exp=0", tvalid_b); end
        total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL b2b_end_busy got=%0b exp=0", busy_b); end
        total++; if (pkt_cnt_b !== 32'd3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", pkt_cnt_b); end
    endtask

    // Sends one packet with tready high; gate opened for one cycle only.
    task automatic send_packet(input string name);
        common_gate = 1'b1;
        tick();
        common_gate = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp_data = beat_val(exp_seq, k);
            total++; if (tvalid !== 1'b1) begin bad++; $display("FAIL %s_tvalid beat=%0d got=%0b exp=1", name, k, tvalid); end
            total++; if (tdata !== exp_data) begin bad++; $display("FAIL %s_tdata beat=%0d got=%h exp=%h", name, k, tdata, exp_data); end
            total++; if (tlast !== (k == 15)) begin bad++; $display("FAIL %s_tlast beat=%0d got=%0b", name, k, tlast); end
            tick();
        end
        exp_seq = exp_seq + 32'd1;
        exp_cnt = exp_cnt + 32'd1;
        total++; if (pkt_cnt !== exp_cnt) begin bad++; $display("FAIL %s_count got=%0d exp=%0d", name, pkt_cnt, exp_cnt); end
    endtask

    task automatic test_single();
        total++; if (pkt_cnt !== 32'd0) begin bad++; $display("FAIL single_count_before got=%0d exp=0", pkt_cnt); end
        send_packet("single");
        for (int g = 0; g < 4; g++) begin
            total++; if (tvalid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL single_gap cyc=%0d tvalid=%0b busy=%0b exp 0/1", g, tvalid, busy); end
            tick();
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_stall();
        int k;
        k = 0;
        common_gate = 1'b1;
        tick();
        common_gate = 1'b0;
        for (int c = 0; c < 31; c++) begin
            tready = ((c % 2) == 0);
            exp_data = beat_val(exp_seq, k);
            total++; if (tvalid !== 1'b1) begin bad++; $display("FAIL stall_tvalid cyc=%0d got=%0b exp=1", c, tvalid); end
            total++; if (tdata !== exp_data) begin bad++; $display("FAIL stall_tdata cyc=%0d got=%h exp=%h", c, tdata, exp_data); end
            total++; if (tlast !== (k == 15)) begin bad++; $display("FAIL stall_tlast cyc=%0d got=%0b", c, tlast); end
            if (tready) k++;
            tick();
        end
        tready = 1'b1;
        exp_seq = exp_seq + 32'd1;
        exp_cnt = exp_cnt + 32'd1;
`ifdef GATED_PKT_GEN_STATS_EN
        exp_stall = 32'd15;
`else
        exp_stall = 32'd0;
`endif
        total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL stall_done_tvalid got=%0b exp=0", tvalid); end
        total++; if (pkt_cnt !== exp_cnt) begin bad++; $display("FAIL stall_count_pkts got=%0d exp=%0d", pkt_cnt, exp_cnt); end
        total++; if (stall !== exp_stall) begin bad++; $display("FAIL stall_cycles got=%0d exp=%0d", stall, exp_stall); end
        repeat (4) tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_idle_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_gate_drop();
        common_gate = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            if (k == 5) common_gate = 1'b0;
            exp_data = beat_val(exp_seq, k);
            total++; if (tvalid !== 1'b1) begin bad++; $display("FAIL drop_tvalid beat=%0d got=%0b exp=1", k, tvalid); end
            total++; if (tdata !== exp_data) begin bad++; $display("FAIL drop_tdata beat=%0d got=%h exp=%h", k, tdata, exp_data); end
            total++; if (tlast !== (k == 15)) begin bad++; $display("FAIL drop_tlast beat=%0d got=%0b", k, tlast); end
            tick();
        end
        exp_seq = exp_seq + 32'd1;
        exp_cnt = exp_cnt + 32'd1;
        total++; if (pkt_cnt !== exp_cnt) begin bad++; $display("FAIL drop_count got=%0d exp=%0d", pkt_cnt, exp_cnt); end
        repeat (4) tick();
        total++; if (busy !== 1'b0 || tvalid !== 1'b0) begin bad++; $display("FAIL drop_idle busy=%0b tvalid=%0b exp=0/0", busy, tvalid); end
        total++; if (stall !== exp_stall) begin bad++; $display("FAIL drop_stall got=%0d exp=%0d", stall, exp_stall); end
    endtask

    task automatic test_common_rst();
        common_rst = 1'b1;
        tick();
        common_rst = 1'b0;
        exp_seq = 32'd0; exp_cnt = 32'd0; exp_stall = 32'd0;
        total++; if (pkt_cnt !== 32'd0) begin bad++; $display("FAIL clr_idle_count got=%0d exp=0", pkt_cnt); end
        total++; if (stall !== 32'd0) begin bad++; $display("FAIL clr_idle_stall got=%0d exp=0", stall); end
        send_packet("clr_p1");
        repeat (4) tick();
        common_gate = 1'b1;
        tick();
        common_gate = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp_data = beat_val(exp_seq, k);
            if (k <= 8) begin
                total++; if (tdata !== exp_data) begin bad++; $display("FAIL clr_p2_tdata beat=%0d got=%h exp=%h", k, tdata, exp_data); end
            end
            total++; if (tvalid !== 1'b1) begin bad++; $display("FAIL clr_p2_tvalid beat=%0d got=%0b exp=1", k, tvalid); end
            total++; if (tlast !== (k == 15)) begin bad++; $display("FAIL clr_p2_tlast beat=%0d got=%0b", k, tlast); end
            if (k == 8) common_rst = 1'b1;
            tick();
            common_rst = 1'b0;
        end
        exp_seq = 32'd0; exp_cnt = 32'd0;
        total++; if (pkt_cnt !== 32'd0) begin bad++; $display("FAIL clr_p2_count got=%0d exp=0", pkt_cnt); end
        total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL clr_p2_end_tvalid got=%0b exp=0", tvalid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL clr_p2_end_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_aresetn();
        common_gate = 1'b1;
        tick();
        common_gate = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_data = beat_val(exp_seq, k);
            total++; if (tdata !== exp_data) begin bad++; $display("FAIL ares_tdata beat=%0d got=%h exp=%h", k, tdata, exp_data); end
            if (k < 3) tick();
        end
        aresetn = 1'b0;
        tick();
        total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL ares_tvalid got=%0b exp=0", tvalid); end
        total++; if (tlast !== 1'b0) begin bad++; $display("FAIL ares_tlast got=%0b exp=0", tlast); end
        total++; if (tdata !== 64'd0) begin bad++; $display("FAIL ares_tdata_zero got=%h exp=0", tdata); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ares_busy got=%0b exp=0", busy); end
        total++; if (pkt_cnt !== 32'd0) begin bad++; $display("FAIL ares_count got=%0d exp=0", pkt_cnt); end
        total++; if (stall !== 32'd0) begin bad++; $display("FAIL ares_stall got=%0d exp=0", stall); end
        aresetn = 1'b1;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ares_after_busy got=%0b exp=0", busy); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_back_to_back();
        test_single();
        test_stall();
        test_gate_drop();
        test_common_rst();
        test_aresetn();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gated_pkt_gen.md
GATED_PKT_GEN -- requirements
Module: gated_pkt_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: AXI-Stream data width in bits, a multiple of 32, minimum 64.
REQ-002 SHALL have parameter PKT_WORDS, default 16: beats per packet, range 2..65535.
REQ-003 SHALL have parameter IFG_CYCLES, default 4: idle cycles between packets, range 0..255.
REQ-004 SHALL have port aclk, input, 1 bit: clock; all logic is on the rising edge.
REQ-005 SHALL have port aresetn, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port common_rst, input, 1 bit: soft clear from the upstream control block; level-sensitive.
REQ-007 SHALL have port common_gate, input, 1 bit: transmit enable from the upstream control block.
REQ-008 SHALL have port m_axis_tdata, output, DATA_WIDTH bits: stream data.
REQ-009 SHALL have port m_axis_tkeep, output, DATA_WIDTH/8 bits: always all-ones.
REQ-010 SHALL have port m_axis_tvalid, output, 1 bit.
REQ-011 SHALL have port m_axis_tready, input, 1 bit.
REQ-012 SHALL have port m_axis_tlast, output, 1 bit.
REQ-013 SHALL have port tx_pkt_count, output, 32 bits: number of completed packets.
REQ-014 SHALL have port busy, output, 1 bit: high when the state is not IDLE.
REQ-015 SHALL have port stall_count, output, 32 bits: cycles with tvalid high and tready low (see Configuration).

Function
REQ-016 SHALL implement a state machine with states IDLE, SEND and GAP.
REQ-017 IDLE->SEND SHALL occur when common_gate=1 and common_rst=0; tvalid SHALL rise on the cycle after the transition.
REQ-018 In SEND, a beat SHALL be transferred only when tvalid and tready are both high; the beat index SHALL advance 0..PKT_WORDS-1 only on a transfer.
REQ-019 While tvalid is high, tdata and tlast SHALL be held stable and tvalid SHALL NOT drop until the beat transfers.
REQ-020 Beat 0 tdata SHALL be {zeros, seq[31:0], PKT_WORDS[15:0], 16'hA5A5}; beat k>0 SHALL be {zeros, seq[31:0], k[31:0]}, with the header packed LSB-first.
REQ-021 tlast SHALL be high exactly on beat PKT_WORDS-1.
REQ-022 On transfer of the tlast beat: tx_pkt_count and seq SHALL increment by 1 (wrapping at 2^32), and the state SHALL go to GAP, or to IDLE if IFG_CYCLES=0 and the gate is low.
REQ-023 If IFG_CYCLES=0 and common_gate=1, SEND SHALL restart with tvalid held high (back-to-back packets, no bubble).
REQ-024 GAP SHALL last exactly IFG_CYCLES cycles with tvalid=0, then go to SEND if common_gate=1, otherwise to IDLE.
REQ-025 Deasserting common_gate mid-packet SHALL NOT truncate the packet; the gate is sampled only in IDLE and at the end of GAP.
REQ-026 While common_rst=1: tx_pkt_count, seq and stall_count SHALL be held at 0; a packet in progress SHALL complete per REQ-019 and REQ-021, then the state SHALL go to IDLE with no count increment; the IDLE->SEND transition SHALL be blocked.
REQ-027 If common_rst and the tlast transfer occur in the same cycle, the clear SHALL win and the counts SHALL read 0.

Reset
REQ-028 On aresetn=0, the block SHALL enter IDLE with tvalid=0, tlast=0, tdata=0, busy=0, tx_pkt_count=0, stall_count=0, seq=0, and the beat and gap counters at 0, aborting any packet immediately.

Configuration
REQ-029 With macro GATED_PKT_GEN_STATS_EN defined, stall_count SHALL increment (saturating at 2^32-1) on every cycle with tvalid=1 and tready=0.
REQ-030 Without GATED_PKT_GEN_STATS_EN, stall_count SHALL be constant 0, no counter logic SHALL be present, and the port list SHALL be unchanged.

Structure
REQ-031 Package gated_pkt_gen_pkg SHALL hold the state enum (IDLE/SEND/GAP), the header magic constant 16'hA5A5 and the header field widths.
REQ-032 Stall counting SHALL live in a single sub-module gated_pkt_gen_stats, instantiated only under GATED_PKT_GEN_STATS_EN.

Verification
REQ-033 With defaults, tready=1 and the gate held for 1 packet: 16 beats, tlast on beat 15, beat 0 = 0x00000000_00_10_A5A5 with seq 0, tx_pkt_count 0->1, followed by 4 idle cycles.
REQ-034 With tready toggling 1/0 every cycle: the packet takes 31 cycles, tdata is stable during stalls, stall_count=15 (macro on) or 0 (macro off).
REQ-035 With IFG_CYCLES=0 and the gate held for 3 packets: 48 consecutive valid beats, seq 0,1,2 in the beat headers, tx_pkt_count=3.
REQ-036 With the gate dropped at beat 5: all 16 beats still sent, then IDLE and busy=0.
REQ-037 With common_rst pulsed at beat 8 of packet 2 (tx_pkt_count=1): the packet completes, the count reads 0, and the next packet carries seq 0.
REQ-038 With aresetn low at beat 3: tvalid drops next cycle, and all outputs are at their reset values.
